// File: rtl/decoder_seq.sv
// Registered index decoder: one-hot hold, thermometer hold, or auto-scan
// of the one-hot select with a programmable dwell per index.
module decoder_seq #(
    parameter int IN_W  = 4,
    parameter int OUT_W = 1 << IN_W,
    parameter int DWELL = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in,
    input  logic [1:0]       mode,
    input  logic             stop,
    output logic [OUT_W-1:0] sel,
    output logic [IN_W-1:0]  idx,
    output logic             busy,
    output logic             wrap
);

    if (IN_W < 1 || IN_W > 8) begin : g_bad_in_w
        $error("decoder_seq: IN_W must be in 1..8");
    end
    if (OUT_W != (1 << IN_W)) begin : g_bad_out_w
        $error("decoder_seq: OUT_W is derived and must equal 1<<IN_W");
    end
    if (DWELL < 1 || DWELL > 255) begin : g_bad_dwell
        $error("decoder_seq: DWELL must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        SCAN
    } state_t;

    localparam logic [7:0]      DWELL_LAST = 8'(DWELL - 1);
    localparam logic [IN_W-1:0] ONE        = 1;
    localparam logic [IN_W-1:0] IDX_MAX    = '1;

    state_t             state_q, state_d;
    logic [1:0]         mode_q, mode_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [IN_W-1:0]    idx_d;
    logic               wrap_d;
    logic [OUT_W-1:0]   sel_d;
    logic [31:0]        idx_w;

    assign in_ready = enable;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            mode_q  <= 2'b00;
            cnt_q   <= '0;
            idx     <= '0;
            sel     <= '0;
            busy    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            idx     <= idx_d;
            sel     <= sel_d;
            busy    <= (state_d == SCAN);
            wrap    <= wrap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        cnt_d   = cnt_q;
        idx_d   = idx;
        wrap_d  = 1'b0;
        sel_d   = '0;
        idx_w   = '0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else if (in_valid) begin
            idx_d   = in;
            mode_d  = mode;
            cnt_d   = '0;
            state_d = (mode == 2'b01 || mode == 2'b10) ? SCAN : HOLD;
        end else if (state_q == SCAN) begin
            if (stop) begin
                state_d = HOLD;
                cnt_d   = '0;
            end else if (cnt_q == DWELL_LAST) begin
                cnt_d = '0;
                if (mode_q == 2'b10) begin
                    idx_d  = idx - ONE;
                    wrap_d = (idx == '0);
                end else begin
                    idx_d  = idx + ONE;
                    wrap_d = (idx == IDX_MAX);
                end
            end else begin
                cnt_d = cnt_q + 8'd1;
            end
        end

        // Select is decoded from the next-state values so it lands on the same edge as idx.
        idx_w = 32'(idx_d);
        if (state_d != IDLE) begin
            for (int unsigned i = 0; i < OUT_W; i++) begin
                sel_d[i] = (mode_d == 2'b11) ? (i <= idx_w) : (i == idx_w);
            end
        end
    end

endmodule

// File: tb/tb_decoder_seq.sv
// Bench for decoder_seq: three parameterisations driven in lockstep, checked
// against a cycle-level reference model plus directed expectations.
module tb_decoder_seq;

    logic        clk = 1'b0;
    logic        reset, enable, in_valid, stop;
    logic [1:0]  mode;
    logic [3:0]  in4;
    logic [2:0]  in3;

    logic [15:0] sel_a, sel_b;
    logic [7:0]  sel_c;
    logic [3:0]  idx_a, idx_b;
    logic [2:0]  idx_c;
    logic        busy_a, busy_b, busy_c;
    logic        wrap_a, wrap_b, wrap_c;
    logic        rdy_a, rdy_b, rdy_c;

    assign in3 = in4[2:0];

    decoder_seq #(.IN_W(4), .DWELL(2)) u_a (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy_a),
        .in(in4), .mode(mode), .stop(stop), .sel(sel_a), .idx(idx_a), .busy(busy_a), .wrap(wrap_a)
    );
    decoder_seq #(.IN_W(4), .DWELL(1)) u_b (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy_b),
        .in(in4), .mode(mode), .stop(stop), .sel(sel_b), .idx(idx_b), .busy(busy_b), .wrap(wrap_b)
    );
    decoder_seq #(.IN_W(3), .DWELL(3)) u_c (
        .clk(clk), .reset(reset), .enable(enable), .in_valid(in_valid), .in_ready(rdy_c),
        .in(in3), .mode(mode), .stop(stop), .sel(sel_c), .idx(idx_c), .busy(busy_c), .wrap(wrap_c)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Model per instance: 0 = A (16 outputs, dwell 2), 1 = B (16, 1), 2 = C (8, 3).
    int nn[3] = '{16, 16, 8};
    int dw[3] = '{2, 1, 3};
    int m_on[3], m_scan[3], m_idx[3], m_mode[3], m_left[3], m_wrap[3];

    logic [15:0] exp_a_up [5] = '{16'h4000, 16'h4000, 16'h8000, 16'h8000, 16'h0001};
    logic [7:0]  exp_c_up [9] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01, 8'h01};

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int exp_sel(int k);
        if (m_on[k] == 0) return 0;
        if (m_mode[k] == 3) return (2 << m_idx[k]) - 1;
        return 1 << m_idx[k];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_on[k] = 0; m_scan[k] = 0; m_idx[k] = 0;
            m_mode[k] = 0; m_left[k] = 0; m_wrap[k] = 0;
        end
    endtask

    task automatic model_step();
        int dir;
        if (reset) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            m_wrap[k] = 0;
            if (!enable) begin
                m_on[k] = 0;
                m_scan[k] = 0;
            end else if (in_valid) begin
                m_idx[k]  = int'(in4) % nn[k];
                m_mode[k] = int'(mode);
                m_on[k]   = 1;
                m_scan[k] = (mode == 2'd1 || mode == 2'd2) ? 1 : 0;
                m_left[k] = dw[k];
            end else if (m_scan[k] != 0 && stop) begin
                m_scan[k] = 0;
            end else if (m_scan[k] != 0) begin
                m_left[k]--;
                if (m_left[k] == 0) begin
                    dir = (m_mode[k] == 1) ? 1 : -1;
                    m_wrap[k] = ((dir == 1 && m_idx[k] == nn[k] - 1) || (dir == -1 && m_idx[k] == 0)) ? 1 : 0;
                    m_idx[k]  = (m_idx[k] + dir + nn[k]) % nn[k];
                    m_left[k] = dw[k];
                end
            end
        end
    endtask

    task automatic check_all();
        check("a_sel",  32'(sel_a),  exp_sel(0));
        check("a_idx",  32'(idx_a),  m_idx[0]);
        check("a_busy", 32'(busy_a), m_scan[0]);
        check("a_wrap", 32'(wrap_a), m_wrap[0]);
        check("a_rdy",  32'(rdy_a),  32'(enable));
        check("b_sel",  32'(sel_b),  exp_sel(1));
        check("b_idx",  32'(idx_b),  m_idx[1]);
        check("b_busy", 32'(busy_b), m_scan[1]);
        check("b_wrap", 32'(wrap_b), m_wrap[1]);
        check("b_rdy",  32'(rdy_b),  32'(enable));
        check("c_sel",  32'(sel_c),  exp_sel(2));
        check("c_idx",  32'(idx_c),  m_idx[2]);
        check("c_busy", 32'(busy_c), m_scan[2]);
        check("c_wrap", 32'(wrap_c), m_wrap[2]);
        check("c_rdy",  32'(rdy_c),  32'(enable));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_all();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; in_valid = 1'b0; stop = 1'b0;
        mode = 2'b00; in4 = 4'd0;
        model_reset();

        // Reset takes effect before any clock edge.
        #3;
        check_all();
        check("rst_sel_a", 32'(sel_a), 32'h0);
        cycle();
        cycle();
        reset = 1'b0;
        cycle();
        cycle();
        check("idle_sel_a", 32'(sel_a), 32'h0);

        // One-hot and thermometer loads.
        enable = 1'b1; in_valid = 1'b1; in4 = 4'd5; mode = 2'b00;
        cycle();
        check("load5_sel_a", 32'(sel_a), 32'h0020);
        in_valid = 1'b0;
        cycle();
        cycle();
        check("hold5_sel_a", 32'(sel_a), 32'h0020);
        in_valid = 1'b1; in4 = 4'd3; mode = 2'b11;
        cycle();
        check("therm3_sel_a", 32'(sel_a), 32'h000F);
        in4 = 4'd15;
        cycle();
        check("therm15_sel_a", 32'(sel_a), 32'hFFFF);
        check("therm7_sel_c", 32'(sel_c), 32'hFF);

        // Scan up: A from 14 with dwell 2, C from 6 with dwell 3.
        in4 = 4'd14; mode = 2'b01;
        cycle();
        in_valid = 1'b0;
        for (int j = 0; j < 9; j++) begin
            if (j > 0) cycle();
            if (j < 5) begin
                check("up_sel_a",  32'(sel_a),  32'(exp_a_up[j]));
                check("up_wrap_a", 32'(wrap_a), (j == 4) ? 32'd1 : 32'd0);
                check("up_busy_a", 32'(busy_a), 32'd1);
            end
            check("up_sel_c",  32'(sel_c),  32'(exp_c_up[j]));
            check("up_wrap_c", 32'(wrap_c), (j == 6) ? 32'd1 : 32'd0);
        end

        // Asynchronous reset in the middle of a dwell.
        async_reset();
        check("rst_mid_sel_c",  32'(sel_c),  32'h0);
        check("rst_mid_busy_c", 32'(busy_c), 32'h0);

        // Scan down with dwell 1, then stop.
        in_valid = 1'b1; in4 = 4'd1; mode = 2'b10;
        cycle();
        check("dn_sel_b0", 32'(sel_b), 32'h0002);
        in_valid = 1'b0;
        cycle();
        check("dn_sel_b1", 32'(sel_b), 32'h0001);
        cycle();
        check("dn_sel_b2",  32'(sel_b),  32'h8000);
        check("dn_wrap_b2", 32'(wrap_b), 32'd1);
        stop = 1'b1;
        cycle();
        check("stop_sel_b",  32'(sel_b),  32'h8000);
        check("stop_busy_b", 32'(busy_b), 32'd0);
        stop = 1'b0;
        cycle();

        // Accept outranks stop; then enable low clears select but keeps idx.
        in_valid = 1'b1; in4 = 4'd9; mode = 2'b01;
        cycle();
        in4 = 4'd7; mode = 2'b00; stop = 1'b1;
        cycle();
        check("prio_sel_a",  32'(sel_a),  32'h0080);
        check("prio_busy_a", 32'(busy_a), 32'd0);
        check("prio_wrap_a", 32'(wrap_a), 32'd0);
        in_valid = 1'b0; stop = 1'b0;
        cycle();
        enable = 1'b0; in_valid = 1'b1; in4 = 4'd2;
        cycle();
        check("dis_sel_a", 32'(sel_a), 32'h0);
        check("dis_idx_a", 32'(idx_a), 32'd7);
        cycle();
        check("dis_idx_a2", 32'(idx_a), 32'd7);
        in_valid = 1'b0; enable = 1'b1;

        // Randomised traffic against the model.
        repeat (500) begin
            enable   = ($urandom_range(0, 15) != 0);
            in_valid = ($urandom_range(0, 7) == 0);
            stop     = ($urandom_range(0, 11) == 0);
            mode     = 2'($urandom);
            in4      = 4'($urandom);
            cycle();
            if ($urandom_range(0, 99) == 0) async_reset();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
